// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed 4-digit 7-segment anode scanner with anti-ghosting blank window.
// Optional dimming feature selected by macro SEG7_SCAN_DIM_EN (adds BRIGHTNESS input).
module seg7_scan_ctrl #(
    parameter int unsigned DIGIT_CYCLES = 100000,
    parameter int unsigned BLANK_CYCLES = 1000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [3:0] DIGIT_EN,
`ifdef SEG7_SCAN_DIM_EN
    input  logic [1:0] BRIGHTNESS,
`endif
    output logic [1:0] MUX_SEL,
    output logic [3:0] ANODE,
    output logic       SLOT_STROBE
);

    localparam int unsigned CntW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast  = CntW'(DIGIT_CYCLES - 1);
    localparam logic [CntW-1:0] CntBlank = CntW'(BLANK_CYCLES);

    localparam logic [0:0] StBlank = 1'b0;
    localparam logic [0:0] StDrive = 1'b1;

    logic [CntW-1:0] cnt_q, cnt_d;
    logic [0:0]      state_q, state_d;
    logic [1:0]      mux_q, mux_d;
    logic [3:0]      anode_q, anode_d;
    logic            strobe_q, strobe_d;
    logic [3:0]      en_q, en_d;
    logic            wrap;
    logic            lit;

`ifdef SEG7_SCAN_DIM_EN
    localparam int unsigned DriveW = DIGIT_CYCLES - BLANK_CYCLES;
    logic [1:0]  bright_q, bright_d;
    logic [31:0] on_end;
`endif

    assign wrap = (cnt_q == CntLast);

    // Outputs are computed from next-state so the registered anode lines up with cnt_q.
    always_comb begin
        cnt_d    = wrap ? '0 : cnt_q + 1'b1;
        mux_d    = wrap ? mux_q + 2'd1 : mux_q;
        en_d     = wrap ? DIGIT_EN : en_q;
        strobe_d = wrap;
        state_d  = (cnt_d < CntBlank) ? StBlank : StDrive;
        lit      = (state_d == StDrive) && en_d[mux_d];
`ifdef SEG7_SCAN_DIM_EN
        bright_d = wrap ? BRIGHTNESS : bright_q;
        on_end   = BLANK_CYCLES + ((DriveW * (32'(bright_d) + 32'd1)) >> 2);
        lit      = lit && (32'(cnt_d) < on_end);
`endif
        anode_d  = lit ? ~(4'b0001 << mux_d) : 4'b1111;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            cnt_q    <= '0;
            state_q  <= StBlank;
            mux_q    <= 2'b00;
            anode_q  <= 4'b1111;
            strobe_q <= 1'b0;
            en_q     <= 4'b0000;
`ifdef SEG7_SCAN_DIM_EN
            bright_q <= 2'b11;
`endif
        end else begin
            cnt_q    <= cnt_d;
            state_q  <= state_d;
            mux_q    <= mux_d;
            anode_q  <= anode_d;
            strobe_q <= strobe_d;
            en_q     <= en_d;
`ifdef SEG7_SCAN_DIM_EN
            bright_q <= bright_d;
`endif
        end
    end

    assign MUX_SEL     = mux_q;
    assign ANODE       = anode_q;
    assign SLOT_STROBE = strobe_q;

`ifndef SYNTHESIS
    a_one_hot_low: assert property (@(posedge CLK) disable iff (RESET)
        $countones(~ANODE) <= 1);
    a_dark_in_blank: assert property (@(posedge CLK) disable iff (RESET)
        (state_q == StBlank) |-> (ANODE == 4'b1111));
`endif

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl; a reference model pushes expected outputs per edge,
// the negedge sampler pops and compares. Honours SEG7_SCAN_DIM_EN when defined.
module tb_seg7_scan_ctrl;

`ifdef SEG7_SCAN_DIM_EN
    localparam int unsigned DC = 10;
`else
    localparam int unsigned DC = 8;
`endif
    localparam int unsigned BC = 2;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic [3:0] DIGIT_EN = 4'b0000;
    logic [1:0] MUX_SEL;
    logic [3:0] ANODE;
    logic       SLOT_STROBE;
`ifdef SEG7_SCAN_DIM_EN
    logic [1:0] BRIGHTNESS = 2'b01;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [3:0] anode;
        logic [1:0] sel;
        logic       strobe;
    } exp_t;

    exp_t sb_q[$];

    int unsigned m_cnt    = 0;
    logic [1:0]  m_slot   = 2'd0;
    logic [3:0]  m_en     = 4'b0000;
    logic [1:0]  m_br     = 2'b11;
    logic        m_strobe = 1'b0;

    seg7_scan_ctrl #(
        .DIGIT_CYCLES(DC),
        .BLANK_CYCLES(BC)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .DIGIT_EN   (DIGIT_EN),
`ifdef SEG7_SCAN_DIM_EN
        .BRIGHTNESS (BRIGHTNESS),
`endif
        .MUX_SEL    (MUX_SEL),
        .ANODE      (ANODE),
        .SLOT_STROBE(SLOT_STROBE)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: advance on each edge, push what the outputs must show afterwards.
    always @(posedge CLK) begin : model
        exp_t        e;
        int unsigned lim;
        if (RESET) begin
            m_cnt    = 0;
            m_slot   = 2'd0;
            m_en     = 4'b0000;
            m_br     = 2'b11;
            m_strobe = 1'b0;
        end else if (m_cnt == DC - 1) begin
            m_cnt    = 0;
            m_slot   = m_slot + 2'd1;
            m_en     = DIGIT_EN;
`ifdef SEG7_SCAN_DIM_EN
            m_br     = BRIGHTNESS;
`endif
            m_strobe = 1'b1;
        end else begin
            m_cnt    = m_cnt + 1;
            m_strobe = 1'b0;
        end
`ifdef SEG7_SCAN_DIM_EN
        lim = BC + (((DC - BC) * (int'(m_br) + 1)) >> 2);
`else
        lim = DC;
`endif
        e.anode  = (m_cnt >= BC && m_cnt < lim && m_en[m_slot]) ? ~(4'b0001 << m_slot) : 4'b1111;
        e.sel    = m_slot;
        e.strobe = m_strobe;
        sb_q.push_back(e);
    end

    always @(negedge CLK) begin : compare
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("anode", 32'(ANODE), 32'(e.anode));
            check("mux_sel", 32'(MUX_SEL), 32'(e.sel));
            check("strobe", 32'(SLOT_STROBE), 32'(e.strobe));
        end
    end

    task automatic run(input int unsigned n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic wait_for(input logic [1:0] slot, input int unsigned cnt);
        for (int i = 0; i < 200; i++) begin
            if (m_slot == slot && m_cnt == cnt) return;
            @(negedge CLK);
        end
        checks++;
        errors++;
        $display("FAIL wait_for: slot %0d cnt %0d not reached within bound", slot, cnt);
    endtask

    initial begin
        repeat (3) @(negedge CLK);
        RESET    = 1'b0;
        DIGIT_EN = 4'b1111;
        run(5 * DC);

        DIGIT_EN = 4'b0101;
        run(4 * DC);

        DIGIT_EN = 4'b1111;
        run(DC);
        // Mid-slot disable of digit 2: current slot keeps driving, next slot 2 stays dark.
        wait_for(2'd2, 4);
        DIGIT_EN = 4'b1011;
        run(5 * DC);

        DIGIT_EN = 4'b1111;
        run(DC);
        wait_for(2'd3, 5);
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        run(2 * DC);

        DIGIT_EN = 4'b0000;
        run(3 * DC);

`ifdef SEG7_SCAN_DIM_EN
        DIGIT_EN   = 4'b1111;
        BRIGHTNESS = 2'b11;
        run(3 * DC);
        BRIGHTNESS = 2'b10;
        run(3 * DC);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seg7_scan_ctrl.md
SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

Interface
REQ-001 Parameter DIGIT_CYCLES, default 100000, SHALL be the CLK cycles per digit slot (blank + drive); legal range >= BLANK_CYCLES+4.
REQ-002 Parameter BLANK_CYCLES, default 1000, SHALL be the anti-ghosting blank cycles at the start of each slot; legal range >= 1.
REQ-003 CLK  in  1  SHALL be the single rising-edge clock.
REQ-004 RESET  in  1  SHALL be the synchronous, active-high reset.
REQ-005 DIGIT_EN  in  4  SHALL give the per-digit enable; bit n enables digit n.
REQ-006 MUX_SEL  out  2  SHALL drive the downstream 4:1 nibble mux CONTROL select.
REQ-007 ANODE  out  4  SHALL carry the active-low digit anodes; bit n is digit n.
REQ-008 SLOT_STROBE  out  1  SHALL be a one-cycle pulse on each slot start.
REQ-009 BRIGHTNESS  in  2  SHALL give the dim level; present only when SEG7_SCAN_DIM_EN is defined.

Function
REQ-010 All outputs SHALL be registered, with no combinational path from input to output.
REQ-011 Slot counter CNT SHALL count 0..DIGIT_CYCLES-1 and then wrap to 0; the wrap edge SHALL advance MUX_SEL by 1 mod 4 (3->0).
REQ-012 FSM states SHALL be BLANK (CNT < BLANK_CYCLES) and DRIVE (CNT >= BLANK_CYCLES); BLANK->DRIVE SHALL occur at CNT==BLANK_CYCLES and DRIVE->BLANK at the wrap.
REQ-013 In BLANK, ANODE SHALL be 4'b1111; MUX_SEL SHALL change only at the wrap, so it is stable for the full blank window before any anode drives.
REQ-014 In DRIVE, ANODE SHALL be ~(4'b0001 << MUX_SEL) if the latched enable bit for MUX_SEL is 1, else 4'b1111.
REQ-015 At most one ANODE bit SHALL ever be low.
REQ-016 DIGIT_EN SHALL be latched on the wrap edge (slot start); changes mid-slot SHALL take effect from the next slot only.
REQ-017 Disabled digits SHALL still occupy their slot (no skipping), keeping refresh rate and per-digit duty constant.
REQ-018 SLOT_STROBE SHALL be high for exactly the one cycle in which the new MUX_SEL first appears; the first strobe after reset SHALL occur on the first wrap.
REQ-019 With DIGIT_EN==4'b0000, counting and MUX_SEL stepping SHALL continue with ANODE held at 4'b1111.

Reset
REQ-020 When RESET is high at a CLK edge: CNT=0, state=BLANK, MUX_SEL=2'b00, ANODE=4'b1111, SLOT_STROBE=0, latched enable=4'b0000 (and latched brightness=2'b11 when dim is enabled).
REQ-021 RESET asserted mid-DRIVE SHALL blank ANODE on that same edge; after release, counting SHALL restart from CNT=0 in slot 0.
REQ-022 The first slot after reset SHALL display nothing, since the latched enable is 0; enables take effect from the first wrap.

Configuration
REQ-023 Macro SEG7_SCAN_DIM_EN SHALL select the dimming feature.
- Defined: BRIGHTNESS port exists and is latched at the wrap; with W=DIGIT_CYCLES-BLANK_CYCLES, the anode SHALL be active only for the first (W*(BRIGHTNESS+1))>>2 cycles of DRIVE and then 4'b1111 for the rest of the slot; W SHALL be a multiple of 4.
- Undefined: no BRIGHTNESS port; anode active for all of DRIVE (full brightness).

Verification (DIGIT_CYCLES=8, BLANK_CYCLES=2 unless noted)
REQ-024 Reset then DIGIT_EN=4'b1111 -> slot 0 fully blank; from slot 1: MUX_SEL 1,2,3,0,... every 8 cycles, ANODE=1111 for 2 cycles then 6 cycles of 1101,1011,0111,1110; SLOT_STROBE every 8th cycle.
REQ-025 DIGIT_EN=4'b0101 -> ANODE low only in slots with MUX_SEL 0 and 2; slots 1 and 3 all 1111 with timing unchanged.
REQ-026 Toggle DIGIT_EN bit 2 from 1 to 0 at CNT=4 of slot 2 -> slot 2 still drives 1011 to slot end; next slot 2 stays blank.
REQ-027 Assert RESET at CNT=5 during a MUX_SEL=3 drive -> next edge gives ANODE=1111, MUX_SEL=0, CNT=0, and no strobe until CNT wraps.
REQ-028 With SEG7_SCAN_DIM_EN defined, DIGIT_CYCLES=10, BLANK_CYCLES=2, BRIGHTNESS=2'b01 -> each enabled slot: 2 blank, 4 driven, 4 blank cycles; BRIGHTNESS=2'b11 -> 8 driven.
REQ-029 Over all scenarios, an assertion SHALL check that ANODE never has more than one low bit and never goes low during BLANK.
